// File: rtl/boot_rom_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_rom_arb_pkg : shared types and constants for the boot ROM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package boot_rom_arb_pkg;

  // Owner of the response currently in the single response stage
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [31:0] ROM_ERR_DATA  = 32'h0000_0000;
  localparam int          ROM_DEPTH_DEF = 800;

  // Word index of a byte address inside the ROM window
  function automatic logic [9:0] word_index(input logic [11:0] addr);
    return addr[11:2];
  endfunction

endpackage : boot_rom_arb_pkg
`default_nettype wire

// File: rtl/boot_rom_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_rom_rr_arb : 2-way round-robin arbiter, bit 0 = instr, bit 1 = data
// Rev 1.0
// ---------------------------------------------------------------------------
module boot_rom_rr_arb #(
  parameter bit INSTR_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Set when instr wins the next conflict, i.e. data was granted last
  logic r_prio_instr;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_prio_instr ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_instr <= INSTR_FIRST;
    end else if (o_gnt[0]) begin
      r_prio_instr <= 1'b0;
    end else if (o_gnt[1]) begin
      r_prio_instr <= 1'b1;
    end
  end

endmodule : boot_rom_rr_arb
`default_nettype wire

// File: rtl/boot_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_rom_arbiter : shares the single-port boot ROM between instr and data
// ports with round-robin arbitration and illegal-access filtering. Rev 1.0
// ---------------------------------------------------------------------------
module boot_rom_arbiter
  import boot_rom_arb_pkg::*;
#(
  parameter int AW          = 12,
  parameter int ROM_AW      = 10,
  parameter int ROM_DEPTH   = ROM_DEPTH_DEF,
  parameter bit INSTR_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_req_i,
  input  logic [AW-1:0]     instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [AW-1:0]     data_addr_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  localparam logic [ROM_AW:0] c_depth = (ROM_AW + 1)'(ROM_DEPTH);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic [ROM_AW-1:0] w_instr_idx;
  logic [ROM_AW-1:0] w_data_idx;
  logic              w_instr_legal;
  logic              w_data_legal;
  logic              w_sel_legal;
  logic [ROM_AW-1:0] w_sel_idx;
  logic              w_rom_rd;
  owner_e            w_owner_nxt;
  logic              w_err_nxt;
  logic              w_instr_rv;
  logic              w_data_rv;
  owner_e            r_owner;
  logic              r_err;

  // Reset masks requests so no grant or ROM access escapes while RST is high
  assign w_req = {data_req_i, instr_req_i} & {2{~RST}};

  boot_rom_rr_arb #(
    .INSTR_FIRST (INSTR_FIRST)
  ) u_rr_arb (
    .clk   (CLK),
    .rst   (RST),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign instr_gnt_o = w_gnt[0];
  assign data_gnt_o  = w_gnt[1];

  assign w_instr_idx   = instr_addr_i[ROM_AW+1:2];
  assign w_data_idx    = data_addr_i[ROM_AW+1:2];
  assign w_instr_legal = ({1'b0, w_instr_idx} < c_depth);
  assign w_data_legal  = ({1'b0, w_data_idx} < c_depth) && !data_we_i
                         && (data_addr_i[1:0] == 2'b00);

  assign w_sel_legal = w_gnt[0] ? w_instr_legal : w_data_legal;
  assign w_sel_idx   = w_gnt[0] ? w_instr_idx   : w_data_idx;
  assign w_rom_rd    = (|w_gnt) && w_sel_legal;

  assign rom_csn_o = ~w_rom_rd;
  assign rom_a_o   = w_rom_rd ? w_sel_idx : '0;

  // Instruction fetches are word-granular; low byte-offset bits are ignored
  logic w_unused_lsb;
  assign w_unused_lsb = ^instr_addr_i[1:0];

  generate
    if (AW > ROM_AW + 2) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{instr_addr_i[AW-1:ROM_AW+2], data_addr_i[AW-1:ROM_AW+2]};
    end
  endgenerate

  // Response stage: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Response stage: next state
  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_err_nxt   = 1'b0;
    if (w_gnt[0]) begin
      w_owner_nxt = OWN_INSTR;
      w_err_nxt   = !w_instr_legal;
    end else if (w_gnt[1]) begin
      w_owner_nxt = OWN_DATA;
      w_err_nxt   = !w_data_legal;
    end
  end

  // Response stage: outputs; a response in flight when RST rises is dropped
  always_comb begin
    w_instr_rv     = (r_owner == OWN_INSTR) && !RST;
    w_data_rv      = (r_owner == OWN_DATA) && !RST;
    instr_rvalid_o = w_instr_rv;
    data_rvalid_o  = w_data_rv;
    instr_err_o    = w_instr_rv && r_err;
    data_err_o     = w_data_rv && r_err;
    instr_rdata_o  = (w_instr_rv && !r_err) ? rom_q_i : ROM_ERR_DATA;
    data_rdata_o   = (w_data_rv && !r_err) ? rom_q_i : ROM_ERR_DATA;
  end

endmodule : boot_rom_arbiter
`default_nettype wire
